// File: rtl/window7_streamer.sv
// Sliding 7-sample window generator feeding sorter7: turns a line-delimited pixel
// stream into one centred window per pixel, replicating edge pixels at both line ends.
module window7_streamer #(
    parameter int unsigned DATA_WIDTH = 8
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [DATA_WIDTH-1:0] s_data,
    input  logic                  s_valid,
    input  logic                  s_last,
    output logic                  s_ready,
    output logic [DATA_WIDTH-1:0] win_1,
    output logic [DATA_WIDTH-1:0] win_2,
    output logic [DATA_WIDTH-1:0] win_3,
    output logic [DATA_WIDTH-1:0] win_4,
    output logic [DATA_WIDTH-1:0] win_5,
    output logic [DATA_WIDTH-1:0] win_6,
    output logic [DATA_WIDTH-1:0] win_7,
    output logic                  m_valid,
    output logic                  m_last,
    input  logic                  m_ready
);

    localparam int unsigned TAPS     = 7;
    localparam int unsigned LEAD_W   = 2;
    localparam int unsigned STATE_W  = 2;

    localparam logic [STATE_W-1:0] ST_IDLE  = 2'd0;
    localparam logic [STATE_W-1:0] ST_RUN   = 2'd1;
    localparam logic [STATE_W-1:0] ST_FLUSH = 2'd2;

    localparam logic [LEAD_W-1:0] LEAD_FULL  = 2'd3;
    localparam logic [LEAD_W-1:0] FLUSH_LAST = 2'd2;

    logic [STATE_W-1:0]                 state_q, state_d;
    logic [LEAD_W-1:0]                  lead_q, lead_d;
    logic [LEAD_W-1:0]                  flush_cnt_q, flush_cnt_d;
    logic [TAPS-1:0][DATA_WIDTH-1:0]    win_q, win_d;
    logic                               m_valid_q, m_valid_d;
    logic                               m_last_q, m_last_d;

    logic                               slot_free;
    logic                               accept;
    logic                               shift_en;
    logic [DATA_WIDTH-1:0]              shift_val;

    // Output slot can take a new window when empty or being drained this cycle
    assign slot_free = !m_valid_q || m_ready;
    assign s_ready   = rst_n && slot_free && (state_q != ST_FLUSH);
    assign accept    = s_valid && s_ready;

    always_comb begin
        state_d     = state_q;
        lead_d      = lead_q;
        flush_cnt_d = flush_cnt_q;
        win_d       = win_q;
        m_valid_d   = m_valid_q;
        m_last_d    = m_last_q;
        shift_en    = 1'b0;
        shift_val   = s_data;

        if (slot_free) begin
            m_valid_d = 1'b0;
            m_last_d  = 1'b0;
        end

        case (state_q)
            ST_IDLE: begin
                if (accept) begin
                    win_d   = {TAPS{s_data}};
                    lead_d  = '0;
                    state_d = s_last ? ST_FLUSH : ST_RUN;
                end
            end
            ST_RUN: begin
                if (accept) begin
                    shift_en = 1'b1;
                    if (s_last) begin
                        state_d = ST_FLUSH;
                    end
                end
            end
            ST_FLUSH: begin
                if (slot_free) begin
                    shift_en  = 1'b1;
                    shift_val = win_q[TAPS-1];
                    if (flush_cnt_q == FLUSH_LAST) begin
                        flush_cnt_d = '0;
                        state_d     = ST_IDLE;
                        m_last_d    = 1'b1;
                    end else begin
                        flush_cnt_d = LEAD_W'(flush_cnt_q + LEAD_W'(1));
                    end
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        // A window is complete once three look-ahead samples sit beyond the centre
        if (shift_en) begin
            win_d     = {shift_val, win_q[TAPS-1:1]};
            lead_d    = (lead_q == LEAD_FULL) ? LEAD_FULL : LEAD_W'(lead_q + LEAD_W'(1));
            m_valid_d = (lead_d == LEAD_FULL);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            lead_q      <= '0;
            flush_cnt_q <= '0;
            win_q       <= '0;
            m_valid_q   <= 1'b0;
            m_last_q    <= 1'b0;
        end else begin
            state_q     <= state_d;
            lead_q      <= lead_d;
            flush_cnt_q <= flush_cnt_d;
            win_q       <= win_d;
            m_valid_q   <= m_valid_d;
            m_last_q    <= m_last_d;
        end
    end

    assign win_1   = win_q[0];
    assign win_2   = win_q[1];
    assign win_3   = win_q[2];
    assign win_4   = win_q[3];
    assign win_5   = win_q[4];
    assign win_6   = win_q[5];
    assign win_7   = win_q[6];
    assign m_valid = m_valid_q;
    assign m_last  = m_last_q;

endmodule

// File: tb/tb_window7_streamer.sv
// Scoreboard bench for window7_streamer: directed lines with hand-computed windows.
module tb_window7_streamer;

    localparam int unsigned DW = 8;

    logic          clk = 1'b0;
    logic          rst_n;
    logic [DW-1:0] s_data;
    logic          s_valid;
    logic          s_last;
    logic          s_ready;
    logic [DW-1:0] win_1, win_2, win_3, win_4, win_5, win_6, win_7;
    logic          m_valid;
    logic          m_last;
    logic          m_ready;

    always #5 clk = ~clk;

    window7_streamer #(.DATA_WIDTH(DW)) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .s_data  (s_data),
        .s_valid (s_valid),
        .s_last  (s_last),
        .s_ready (s_ready),
        .win_1   (win_1),
        .win_2   (win_2),
        .win_3   (win_3),
        .win_4   (win_4),
        .win_5   (win_5),
        .win_6   (win_6),
        .win_7   (win_7),
        .m_valid (m_valid),
        .m_last  (m_last),
        .m_ready (m_ready)
    );

    typedef logic [7*DW:0] exp_t;   // {last, win_1 .. win_7}

    exp_t sb[$];
    exp_t mon_e;
    int   tests = 0;
    int   fails = 0;
    int   waited;
    int   lat;

    function automatic exp_t mk(input logic l, input int a, input int b, input int c,
                                input int d, input int e, input int f, input int g);
        return {l, DW'(a), DW'(b), DW'(c), DW'(d), DW'(e), DW'(f), DW'(g)};
    endfunction

    function automatic exp_t act();
        return {m_last, win_1, win_2, win_3, win_4, win_5, win_6, win_7};
    endfunction

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] want);
        tests++;
        if (got !== want) begin
            fails++;
            $display("FAIL %s got=%0h want=%0h", name, got, want);
        end
    endtask

    // Monitor: every consumed window must match the head of the scoreboard
    always @(negedge clk) begin
        if (rst_n && m_valid && m_ready) begin
            tests++;
            if (sb.size() == 0) begin
                fails++;
                $display("FAIL unexpected_window got=%h", act());
            end else begin
                mon_e = sb.pop_front();
                if (act() !== mon_e) begin
                    fails++;
                    $display("FAIL window got=%h want=%h", act(), mon_e);
                end
            end
        end
    end

    task automatic send(input int d, input logic l, output int nwait);
        bit done;
        s_data  = DW'(d);
        s_valid = 1'b1;
        s_last  = l;
        nwait   = 0;
        done    = 1'b0;
        while (!done) begin
            @(negedge clk);
            if (s_ready) begin
                done = 1'b1;
            end else begin
                nwait++;
                if (nwait > 100) begin
                    tests++;
                    fails++;
                    $display("FAIL send_timeout got=s_ready_low want=accept");
                    done = 1'b1;
                end
            end
        end
        @(posedge clk);
        #1;
        s_valid = 1'b0;
        s_last  = 1'b0;
    endtask

    task automatic drain(input string name);
        int n;
        n = 0;
        while (sb.size() != 0 && n < 50) begin
            @(posedge clk);
            n++;
        end
        #1;
        check(name, 64'(sb.size()), 64'd0);
    endtask

    initial begin
        rst_n   = 1'b0;
        s_valid = 1'b0;
        s_data  = '0;
        s_last  = 1'b0;
        m_ready = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        check("reset_s_ready", 64'(s_ready), 64'd0);
        check("reset_m_valid", 64'(m_valid), 64'd0);
        check("reset_m_last",  64'(m_last),  64'd0);
        check("reset_taps",    64'(act()),   64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // Seven-pixel line
        sb.push_back(mk(0, 10, 10, 10, 10, 30, 20, 50));
        sb.push_back(mk(0, 10, 10, 10, 30, 20, 50, 44));
        sb.push_back(mk(0, 10, 10, 30, 20, 50, 44, 100));
        sb.push_back(mk(0, 10, 30, 20, 50, 44, 100, 70));
        sb.push_back(mk(0, 30, 20, 50, 44, 100, 70, 70));
        sb.push_back(mk(0, 20, 50, 44, 100, 70, 70, 70));
        sb.push_back(mk(1, 50, 44, 100, 70, 70, 70, 70));
        send(10, 0, waited);
        send(30, 0, waited);
        send(20, 0, waited);
        send(50, 0, waited);
        send(44, 0, waited);
        send(100, 0, waited);
        send(70, 1, waited);
        drain("drain_line7");

        // Single-pixel line
        sb.push_back(mk(1, 255, 255, 255, 255, 255, 255, 255));
        send(255, 1, waited);
        check("flush_s_ready", 64'(s_ready), 64'd0);
        lat = 0;
        while (lat < 20) begin
            @(posedge clk);
            lat++;
            #1;
            if (m_valid) break;
        end
        check("single_latency", 64'(lat), 64'd3);
        check("single_s_ready", 64'(s_ready), 64'd1);
        drain("drain_single");

        // Two-pixel line
        sb.push_back(mk(0, 100, 100, 100, 100, 20, 20, 20));
        sb.push_back(mk(1, 100, 100, 100, 20, 20, 20, 20));
        send(100, 0, waited);
        send(20, 1, waited);
        drain("drain_line2");
        repeat (5) @(posedge clk);
        #1;

        // Backpressure mid-line
        sb.push_back(mk(0, 1, 1, 1, 1, 2, 3, 4));
        sb.push_back(mk(0, 1, 1, 1, 2, 3, 4, 5));
        sb.push_back(mk(0, 1, 1, 2, 3, 4, 5, 6));
        sb.push_back(mk(0, 1, 2, 3, 4, 5, 6, 6));
        sb.push_back(mk(0, 2, 3, 4, 5, 6, 6, 6));
        sb.push_back(mk(1, 3, 4, 5, 6, 6, 6, 6));
        send(1, 0, waited);
        send(2, 0, waited);
        send(3, 0, waited);
        send(4, 0, waited);
        send(5, 0, waited);
        m_ready = 1'b0;
        s_valid = 1'b1;
        s_data  = DW'(6);
        repeat (5) begin
            @(negedge clk);
            check("bp_s_ready", 64'(s_ready), 64'd0);
            check("bp_m_valid", 64'(m_valid), 64'd1);
            check("bp_taps",    64'(act()),   64'(mk(0, 1, 1, 1, 2, 3, 4, 5)));
        end
        @(posedge clk);
        #1;
        m_ready = 1'b1;
        send(6, 1, waited);
        drain("drain_bp");

        // Back-to-back lines
        sb.push_back(mk(0, 0, 0, 0, 0, 1, 2, 3));
        sb.push_back(mk(0, 0, 0, 0, 1, 2, 3, 4));
        sb.push_back(mk(0, 0, 0, 1, 2, 3, 4, 4));
        sb.push_back(mk(0, 0, 1, 2, 3, 4, 4, 4));
        sb.push_back(mk(1, 1, 2, 3, 4, 4, 4, 4));
        sb.push_back(mk(0, 200, 200, 200, 200, 201, 202, 203));
        sb.push_back(mk(0, 200, 200, 200, 201, 202, 203, 204));
        sb.push_back(mk(0, 200, 200, 201, 202, 203, 204, 204));
        sb.push_back(mk(0, 200, 201, 202, 203, 204, 204, 204));
        sb.push_back(mk(1, 201, 202, 203, 204, 204, 204, 204));
        send(0, 0, waited);
        send(1, 0, waited);
        send(2, 0, waited);
        send(3, 0, waited);
        send(4, 1, waited);
        send(200, 0, waited);
        check("b2b_flush_stall", 64'(waited), 64'd3);
        send(201, 0, waited);
        send(202, 0, waited);
        send(203, 0, waited);
        send(204, 1, waited);
        drain("drain_b2b");

        // Reset asserted while flushing a six-pixel line
        sb.push_back(mk(0, 10, 10, 10, 10, 20, 30, 40));
        sb.push_back(mk(0, 10, 10, 10, 20, 30, 40, 50));
        send(10, 0, waited);
        send(20, 0, waited);
        send(30, 0, waited);
        send(40, 0, waited);
        send(50, 0, waited);
        send(60, 1, waited);
        rst_n = 1'b0;
        #1;
        check("rst_flush_m_valid", 64'(m_valid), 64'd0);
        check("rst_flush_taps",    64'(act()),   64'd0);
        check("rst_flush_s_ready", 64'(s_ready), 64'd0);
        check("rst_flush_sb",      64'(sb.size()), 64'd0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        sb.push_back(mk(0, 7, 7, 7, 7, 8, 9, 9));
        sb.push_back(mk(0, 7, 7, 7, 8, 9, 9, 9));
        sb.push_back(mk(1, 7, 7, 8, 9, 9, 9, 9));
        send(7, 0, waited);
        send(8, 0, waited);
        send(9, 1, waited);
        drain("drain_after_reset");

        repeat (10) @(posedge clk);
        #1;
        check("final_idle_m_valid", 64'(m_valid), 64'd0);
        check("final_sb_empty",     64'(sb.size()), 64'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
